// File: rtl/if_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : if_stage_pkg                                            |
// | Purpose  : Shared constants and fetch FSM encoding for the         |
// |            instruction fetch stage.                                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package if_stage_pkg;

  // Bubble instruction: addi x0,x0,0
  localparam logic [31:0] c_nop_inst = 32'h0000_0013;
  // Default first fetch address after reset
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [1:0] c_st_fetch = 2'd0;  // request on the bus
  localparam logic [1:0] c_st_wait  = 2'd1;  // request accepted, waiting for data
  localparam logic [1:0] c_st_hold  = 2'd2;  // data buffered, waiting for the pipeline
  localparam logic [1:0] c_st_drop  = 2'd3;  // flushed while outstanding, discard data

  // Redirect targets are word-aligned by clearing the two low bits
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : if_id_reg                                               |
// | Purpose  : IF/ID pipeline register with enable, flush and          |
// |            asynchronous reset. Flush has priority over enable.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = c_nop_inst
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_inst,
  input  logic        d_valid,
  output logic [31:0] q_pc,
  output logic [31:0] q_inst,
  output logic        q_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;

  // Pipeline register: flush inserts a bubble, enable loads, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= 32'h0000_0000;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_pc    <= 32'h0000_0000;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (en) begin
      r_pc    <= d_pc;
      r_inst  <= d_inst;
      r_valid <= d_valid;
    end
  end

  assign q_pc    = r_pc;
  assign q_inst  = r_inst;
  assign q_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : if_stage                                                |
// | Purpose  : Instruction fetch stage. Owns the PC and a four-state   |
// |            fetch FSM with a single outstanding memory request, a   |
// |            one-entry hold buffer for stalls, and the IF/ID reg.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] NOP_INST = c_nop_inst
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCen,
  input  logic        IF_IDen,
  input  logic        EX_PCSrc,
  input  logic [31:0] EX_PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Inst,
  output logic        ID_Valid
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;

  logic        w_advance;
  logic [1:0]  w_next_state;
  logic [31:0] w_next_pc;
  logic        w_load_hold;
  logic        w_deliver_wait;
  logic        w_deliver_hold;
  logic [31:0] w_d_pc;
  logic [31:0] w_d_inst;
  logic        w_d_valid;

  assign w_advance = PCen & IF_IDen;

  // Next-state and next-PC logic; a flush overrides every other decision
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_load_hold    = 1'b0;
    w_deliver_wait = 1'b0;
    w_deliver_hold = 1'b0;
    case (r_state)
      c_st_fetch: begin
        // An accepted request being flushed still returns data: drop it
        if (EX_PCSrc)        w_next_state = imem_ready ? c_st_drop : c_st_fetch;
        else if (imem_ready) w_next_state = c_st_wait;
      end
      c_st_wait: begin
        if (EX_PCSrc) begin
          w_next_state = imem_rvalid ? c_st_fetch : c_st_drop;
        end else if (imem_rvalid) begin
          if (w_advance) begin
            w_deliver_wait = 1'b1;
            w_next_pc      = r_pc + 32'd4;
            w_next_state   = c_st_fetch;
          end else begin
            w_load_hold  = 1'b1;
            w_next_state = c_st_hold;
          end
        end
      end
      c_st_hold: begin
        if (EX_PCSrc) begin
          w_next_state = c_st_fetch;
        end else if (w_advance) begin
          w_deliver_hold = 1'b1;
          w_next_pc      = r_pc + 32'd4;
          w_next_state   = c_st_fetch;
        end
      end
      c_st_drop: begin
        // Further flushes here only retarget the PC (handled below)
        if (imem_rvalid) w_next_state = c_st_fetch;
      end
      default: w_next_state = c_st_fetch;
    endcase
    if (EX_PCSrc) w_next_pc = align_word(EX_PCTarget);
  end

  // FSM state and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_fetch;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Hold buffer captures returned data while the pipeline is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_pc   <= 32'h0000_0000;
      r_hold_inst <= 32'h0000_0000;
    end else if (w_load_hold) begin
      r_hold_pc   <= r_pc;
      r_hold_inst <= imem_rdata;
    end
  end

  // Select what IF/ID loads: fresh data, buffered data, or a bubble
  always_comb begin
    w_d_pc    = r_pc;
    w_d_inst  = NOP_INST;
    w_d_valid = 1'b0;
    if (w_deliver_wait) begin
      w_d_inst  = imem_rdata;
      w_d_valid = 1'b1;
    end else if (w_deliver_hold) begin
      w_d_pc    = r_hold_pc;
      w_d_inst  = r_hold_inst;
      w_d_valid = 1'b1;
    end
  end

  // Request is masked during reset so nothing reaches memory until release
  assign imem_req  = (r_state == c_st_fetch) & ~reset;
  assign imem_addr = r_pc;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (IF_IDen),
    .flush   (EX_PCSrc),
    .d_pc    (w_d_pc),
    .d_inst  (w_d_inst),
    .d_valid (w_d_valid),
    .q_pc    (ID_PC),
    .q_inst  (ID_Inst),
    .q_valid (ID_Valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_if_stage                                             |
// | Purpose  : Directed self-checking bench for if_stage.              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_if_stage;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCen, IF_IDen, EX_PCSrc;
  logic [31:0] EX_PCTarget;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req,  imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic [31:0] ID_PC,     ID_PC_w;
  logic [31:0] ID_Inst,   ID_Inst_w;
  logic        ID_Valid,  ID_Valid_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .PCen(PCen), .IF_IDen(IF_IDen),
    .EX_PCSrc(EX_PCSrc), .EX_PCTarget(EX_PCTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ID_PC(ID_PC), .ID_Inst(ID_Inst), .ID_Valid(ID_Valid)
  );

  // Second instance shares stimulus; only its wrap-around start is checked
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .PCen(PCen), .IF_IDen(IF_IDen),
    .EX_PCSrc(EX_PCSrc), .EX_PCTarget(EX_PCTarget),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ID_PC(ID_PC_w), .ID_Inst(ID_Inst_w), .ID_Valid(ID_Valid_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic valid);
    check({tag, "_pc"},    ID_PC,    pc);
    check({tag, "_inst"},  ID_Inst,  inst);
    check({tag, "_valid"}, {31'd0, ID_Valid}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1; PCen = 1'b1; IF_IDen = 1'b1; EX_PCSrc = 1'b0;
    EX_PCTarget = 32'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check_id("rst_id", 32'h0, c_nop, 1'b0);
    check("rst_w_req", {31'd0, imem_req_w}, 32'd0);
    check("rst_w_addr", imem_addr_w, 32'hFFFF_FFFC);
    check("rst_w_id", {ID_PC_w[30:0], ID_Valid_w}, 32'd0);
    check("rst_w_inst", ID_Inst_w, c_nop);

    // Release reset: request appears immediately at RESET_PC
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Streaming fetch 0,4,8 with one-cycle rvalid latency
    tick();                                   // accepted, WAIT
    check("wait0_req", {31'd0, imem_req}, 32'd0);
    check("wait0_valid", {31'd0, ID_Valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
    tick();
    check_id("del0", 32'h0, 32'hDEAD_0000, 1'b1);
    check("addr4", imem_addr, 32'h4);
    check("wrap_addr", imem_addr_w, 32'h0000_0000);
    imem_rvalid = 1'b0;
    tick();
    check_id("bub4", 32'h4, c_nop, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0004;
    tick();
    check_id("del4", 32'h4, 32'hDEAD_0004, 1'b1);
    check("addr8", imem_addr, 32'h8);
    imem_rvalid = 1'b0;
    tick();                                   // accepted PC=8, WAIT

    // Stall when data for PC=8 returns -> HOLD for three cycles
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0008; PCen = 1'b0; IF_IDen = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check_id("hold_id", 32'h8, c_nop, 1'b0);
    tick();
    tick();
    check("hold3_req", {31'd0, imem_req}, 32'd0);
    check("hold3_addr", imem_addr, 32'h8);
    PCen = 1'b1; IF_IDen = 1'b1;
    tick();
    check_id("rel8", 32'h8, 32'hDEAD_0008, 1'b1);
    check("rel_addr", imem_addr, 32'hC);
    check("rel_req", {31'd0, imem_req}, 32'd1);

    // Flush while waiting -> DROP, returning data discarded
    tick();                                   // accepted PC=12, WAIT
    EX_PCSrc = 1'b1; EX_PCTarget = 32'h100;
    tick();
    EX_PCSrc = 1'b0;
    check_id("flush_id", 32'h0, c_nop, 1'b0);
    check("drop_req", {31'd0, imem_req}, 32'd0);
    check("drop_addr", imem_addr, 32'h100);
    tick();
    check("drop_idle_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_000C;
    tick();
    imem_rvalid = 1'b0;
    check("drop_valid", {31'd0, ID_Valid}, 32'd0);
    check("drop_inst", ID_Inst, c_nop);
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);

    // Flush and stall together with unaligned target
    imem_ready = 1'b0; PCen = 1'b0; IF_IDen = 1'b0;
    EX_PCSrc = 1'b1; EX_PCTarget = 32'h203;
    tick();
    EX_PCSrc = 1'b0; PCen = 1'b1; IF_IDen = 1'b1; imem_ready = 1'b1;
    check("fs_addr", imem_addr, 32'h200);
    check_id("fs_id", 32'h0, c_nop, 1'b0);

    // Reset asserted while waiting; stray rvalid afterwards ignored
    tick();                                   // accepted 0x200, WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    check_id("del200", 32'h200, 32'h1234_5678, 1'b1);
    tick();                                   // accepted 0x204, WAIT
    #2;
    reset = 1'b1;
    #1;
    check_id("arst_id", 32'h0, c_nop, 1'b0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    tick();
    reset = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0204;
    tick();
    imem_rvalid = 1'b0;
    check("stray_req", {31'd0, imem_req}, 32'd1);
    check("stray_addr", imem_addr, 32'h0);
    check("stray_valid", {31'd0, ID_Valid}, 32'd0);
    imem_ready = 1'b1;
    tick();                                   // accepted 0x0, WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
    tick();
    imem_rvalid = 1'b0;
    check_id("post_rst", 32'h0, 32'hAAAA_0000, 1'b1);
    check("post_rst_addr", imem_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
